// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment output responder.
//   HEX_SEG      : active-low patterns for hex digits 0..F (bit7=dp, bits6:0=g..a)
//   SEG_BLANK    : all segments off, dp off
//   ST_*         : handshake FSM state encoding
package seg_pkg;

    // Index n holds the pattern for nibble value n; dp (bit7) is always off.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E,  // F
        8'h86,  // E
        8'hA1,  // d
        8'hC6,  // C
        8'h83,  // b
        8'h88,  // A
        8'h90,  // 9
        8'h80,  // 8
        8'hF8,  // 7
        8'h82,  // 6
        8'h92,  // 5
        8'h99,  // 4
        8'hB0,  // 3
        8'hA4,  // 2
        8'hF9,  // 1
        8'hC0   // 0
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ACK       = 2'd1;
    localparam logic [1:0] ST_WAIT_DROP = 2'd2;

endpackage

// File: rtl/seg_output_responder_hex_to_seg.sv
// hex_to_seg: combinational nibble to seven-segment pattern decoder.
//   i_nibble : 4-bit hex value
//   o_seg    : 8-bit active-low segment pattern (bit7=dp, always off)
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg_output_responder.sv
// seg_output_responder: CPU output-port responder driving an 8-digit hex display.
//   clk, rst           : clock, asynchronous active-high reset
//   output_flag        : CPU output request, held until acknowledged
//   output_data        : value to display, sampled on acceptance
//   output_finish_flag : one-cycle acknowledge per accepted request
//   seg_data           : active-low segment pattern of the scanned digit
//   seg_sel            : one-hot digit select, bit n = nibble n
//   led                : count of accepted outputs, modulo 2^16
// Build option: define SEG_LEADING_ZERO_BLANK_EN to blank digits above the
// most significant nonzero nibble (digit 0 is always lit).
module seg_output_responder
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        output_flag,
    input  logic [31:0] output_data,
    output logic        output_finish_flag,
    output logic [7:0]  seg_data,
    output logic [7:0]  seg_sel,
    output logic [15:0] led
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [1:0]       r_state;
    logic [31:0]      r_shown;
    logic [15:0]      r_out_cnt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_cur_digit;
    logic [7:0]       r_seg_sel;
    logic [7:0]       r_seg_data;

    logic [4:0]       w_bit_idx;
    logic [3:0]       w_nibble;
    logic [7:0]       w_seg;
    logic             w_blank;

    // Handshake: accept only from IDLE, so a flag held high is acknowledged once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shown   <= 32'd0;
            r_out_cnt <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (output_flag) begin
                        r_shown   <= output_data;
                        r_out_cnt <= r_out_cnt + 16'd1;
                        r_state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_state <= output_flag ? ST_WAIT_DROP : ST_IDLE;
                end
                ST_WAIT_DROP: begin
                    if (!output_flag) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign output_finish_flag = (r_state == ST_ACK);
    assign led                = r_out_cnt;

    // Digit scan: advance one digit every SCAN_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_cur_digit <= 3'd0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt   <= '0;
            r_cur_digit <= r_cur_digit + 3'd1;
        end else begin
            r_div_cnt   <= r_div_cnt + 1'b1;
        end
    end

    assign w_bit_idx = {r_cur_digit, 2'b00};
    assign w_nibble  = r_shown[w_bit_idx +: 4];

    hex_to_seg u_hex_to_seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Blank when every nibble at or above the current digit is zero.
    assign w_blank = (r_cur_digit != 3'd0) && ((r_shown >> w_bit_idx) == 32'd0);
`else
    assign w_blank = 1'b0;
`endif

    // Registered display outputs; select and pattern always move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_sel  <= 8'h01;
            r_seg_data <= HEX_SEG[0];
        end else begin
            r_seg_sel  <= 8'h01 << r_cur_digit;
            r_seg_data <= w_blank ? SEG_BLANK : w_seg;
        end
    end

    assign seg_sel  = r_seg_sel;
    assign seg_data = r_seg_data;

endmodule

// File: tb/tb_seg_output_responder.sv
// tb_seg_output_responder: self-checking bench for seg_output_responder.
// Honours SEG_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_output_responder;

    localparam int SD = 4;

    // Display patterns indexed by hex value 0..F.
    localparam logic [7:0] HEX_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk;
    logic        rst;
    logic        output_flag;
    logic [31:0] output_data;
    logic        output_finish_flag;
    logic [7:0]  seg_data;
    logic [7:0]  seg_sel;
    logic [15:0] led;

    int errs;
    int checks;

    // Reference model state: edges since reset release, displayed value,
    // accept count, and whether the flag was low (or reset) at the previous edge.
    int          m_n;
    logic [31:0] m_shown;
    logic [15:0] m_cnt;
    logic        m_ready;

    seg_output_responder #(
        .SCAN_DIV (SD)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .output_flag        (output_flag),
        .output_data        (output_data),
        .output_finish_flag (output_finish_flag),
        .seg_data           (seg_data),
        .seg_sel            (seg_sel),
        .led                (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n     = 0;
        m_shown = 32'd0;
        m_cnt   = 16'd0;
        m_ready = 1'b1;
    endtask

    // One clock edge: advance the model, then compare all outputs.
    task automatic step();
        logic       acc;
        int         d;
        int         idx;
        logic [7:0] es;
        @(posedge clk);
        acc = output_flag && m_ready;
        m_n++;
        d   = ((m_n - 1) / SD) % 8;
        idx = int'((m_shown >> (4 * d)) & 32'hF);
        es  = HEX_TBL[idx];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (d != 0 && (m_shown >> (4 * d)) == 32'd0) es = 8'hFF;
`endif
        if (acc) begin
            m_shown = output_data;
            m_cnt   = m_cnt + 16'd1;
        end
        m_ready = !output_flag;
        #1;
        check_eq("finish", 32'(output_finish_flag), 32'(acc));
        check_eq("led", 32'(led), 32'(m_cnt));
        check_eq("seg_sel", 32'(seg_sel), 32'(8'h01 << d));
        check_eq("seg_data", 32'(seg_data), 32'(es));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_eq("rst_seg_sel", 32'(seg_sel), 32'h01);
        check_eq("rst_seg_data", 32'(seg_data), 32'hC0);
        check_eq("rst_led", 32'(led), 32'h0);
        check_eq("rst_finish", 32'(output_finish_flag), 32'h0);
    endtask

    function automatic int sel_index(input logic [7:0] sel);
        int r;
        r = -1;
        for (int k = 0; k < 8; k++) if (sel == (8'h01 << k)) r = k;
        return r;
    endfunction

    initial begin
        int         pulses;
        int         k;
        logic [7:0] seen;
        logic [7:0] scan_exp [8];
        logic [7:0] lit;
        bit         found;

        errs        = 0;
        checks      = 0;
        rst         = 1'b1;
        output_flag = 1'b0;
        output_data = 32'd0;
        model_reset();
        do_reset();

        // Single request held for 5 cycles.
        output_data = 32'h1234ABCD;
        output_flag = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (output_finish_flag) pulses++;
            if (i == 0) check_eq("single_first_ack", 32'(output_finish_flag), 32'h1);
            output_data = $urandom;
        end
        output_flag = 1'b0;
        step();
        check_eq("single_pulses", 32'(pulses), 32'd1);
        check_eq("single_led", 32'(led), 32'd1);
        scan_exp = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        seen = 8'h00;
        for (int i = 0; i < 32; i++) begin
            step();
            k = sel_index(seg_sel);
            if (k >= 0) begin
                seen[k] = 1'b1;
                check_eq("scan_digit", 32'(seg_data), 32'(scan_exp[k]));
            end
        end
        check_eq("scan_all_digits", 32'(seen), 32'hFF);

        // Back-to-back requests with a single low cycle between them.
        do_reset();
        pulses = 0;
        output_data = 32'h5; output_flag = 1'b1; step(); pulses += int'(output_finish_flag);
        output_flag = 1'b0;                      step(); pulses += int'(output_finish_flag);
        output_data = 32'h6; output_flag = 1'b1; step(); pulses += int'(output_finish_flag);
        output_flag = 1'b0;                      step(); pulses += int'(output_finish_flag);
        check_eq("b2b_pulses", 32'(pulses), 32'd2);
        check_eq("b2b_led", 32'(led), 32'd2);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (seg_sel == 8'h01) begin
                found = 1'b1;
                check_eq("b2b_digit0", 32'(seg_data), 32'h82);
            end
        end
        if (!found) check_eq("b2b_digit0_timeout", 32'h0, 32'h1);

        // Counter wrap: preload near the top, then two requests.
        force dut.r_out_cnt = 16'hFFFE;
        m_cnt = 16'hFFFE;
        step();
        release dut.r_out_cnt;
        step();
        output_data = 32'hFFFF0001; output_flag = 1'b1; step();
        output_flag = 1'b0; step();
        check_eq("wrap_ffff", 32'(led), 32'hFFFF);
        output_data = 32'h00000002; output_flag = 1'b1; step();
        output_flag = 1'b0; step();
        check_eq("wrap_zero", 32'(led), 32'h0);

        // Reset asserted during ACK with the flag still high.
        do_reset();
        output_data = 32'hDEADBEEF;
        output_flag = 1'b1;
        step();
        rst = 1'b1;
        #1;
        check_eq("midrst_finish", 32'(output_finish_flag), 32'h0);
        check_eq("midrst_led", 32'(led), 32'h0);
        check_eq("midrst_seg_data", 32'(seg_data), 32'hC0);
        check_eq("midrst_shown", dut.r_shown, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step();
        check_eq("midrst_reack", 32'(output_finish_flag), 32'h1);
        check_eq("midrst_led1", 32'(led), 32'h1);
        output_flag = 1'b0;
        step();

`ifdef SEG_LEADING_ZERO_BLANK_EN
        do_reset();
        output_data = 32'h000000A0; output_flag = 1'b1; step();
        output_flag = 1'b0; step();
        for (int i = 0; i < 32; i++) begin
            step();
            k = sel_index(seg_sel);
            if (k >= 2) check_eq("blank_hi", 32'(seg_data), 32'hFF);
            else if (k == 1) check_eq("blank_d1", 32'(seg_data), 32'h88);
            else if (k == 0) check_eq("blank_d0", 32'(seg_data), 32'hC0);
        end
        output_data = 32'h0; output_flag = 1'b1; step();
        output_flag = 1'b0; step();
        lit = 8'h00;
        for (int i = 0; i < 32; i++) begin
            step();
            k = sel_index(seg_sel);
            if (k >= 0 && seg_data != 8'hFF) lit[k] = 1'b1;
            if (k == 0) check_eq("zero_d0", 32'(seg_data), 32'hC0);
        end
        check_eq("zero_lit", 32'(lit), 32'h01);
`else
        lit = 8'h00;
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            output_flag = ($urandom_range(0, 2) != 0);
            output_data = $urandom;
            if ($urandom_range(0, 3) == 0) output_data = output_data & 32'h0000FFFF;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
